// File: rtl/ps2_key_decoder.sv
// Turns PS/2 make/break activity into Life-game user commands: cursor moves,
// cell toggle, run/pause, single step, clear and speed selection.
module ps2_key_decoder #(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 32,
    parameter int XW         = 5,
    parameter int YW         = 5,
    parameter int SPEED_INIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    ps2_byte,
    input  logic          ps2_state,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          running,
    output logic [2:0]    speed,
    output logic          toggle_pulse,
    output logic          step_pulse,
    output logic          clear_pulse
);

    typedef enum logic {
        PFX_NONE = 1'b0,
        PFX_EXT  = 1'b1
    } prefix_state_t;

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    prefix_state_t prefix_state, prefix_next;
    logic          ext;

    logic       s1_state, s2_state;
    logic [7:0] s1_byte, s2_byte;
    logic       evt, make, brk;

    logic [XW-1:0] cursor_x_next;
    logic [YW-1:0] cursor_y_next;
    logic          running_next;
    logic [2:0]    speed_next;
    logic          toggle_next, step_next, clear_next;

    // Any change of the sampled {state, byte} is an event, so typematic repeats are ignored.
    assign evt  = ({s1_state, s1_byte} != {s2_state, s2_byte});
    assign make = evt & s1_state;
    assign brk  = evt & ~s1_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_state <= 1'b0;
            s1_byte  <= 8'h00;
            s2_state <= 1'b0;
            s2_byte  <= 8'h00;
        end else begin
            s1_state <= ps2_state;
            s1_byte  <= ps2_byte;
            s2_state <= s1_state;
            s2_byte  <= s1_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prefix_state <= PFX_NONE;
        end else begin
            prefix_state <= prefix_next;
        end
    end

    // E0 arms the extended prefix; any break or any other make disarms it.
    always_comb begin
        prefix_next = prefix_state;
        if (make) begin
            prefix_next = (s1_byte == 8'hE0) ? PFX_EXT : PFX_NONE;
        end else if (brk) begin
            prefix_next = PFX_NONE;
        end
    end

    always_comb begin
        ext = (prefix_state == PFX_EXT);
    end

    always_comb begin
        cursor_x_next = cursor_x;
        cursor_y_next = cursor_y;
        running_next  = running;
        speed_next    = speed;
        toggle_next   = 1'b0;
        step_next     = 1'b0;
        clear_next    = 1'b0;
        if (make && (s1_byte != 8'hE0)) begin
            case (s1_byte)
                8'h75, 8'h1D: cursor_y_next = (cursor_y == '0)    ? Y_MAX : cursor_y - 1'b1;
                8'h72, 8'h1B: cursor_y_next = (cursor_y == Y_MAX) ? '0    : cursor_y + 1'b1;
                8'h6B, 8'h1C: cursor_x_next = (cursor_x == '0)    ? X_MAX : cursor_x - 1'b1;
                8'h74, 8'h23: cursor_x_next = (cursor_x == X_MAX) ? '0    : cursor_x + 1'b1;
                8'h5A: running_next = ~running;
                8'h29: toggle_next = ~ext;
                8'h31: step_next = ~ext & ~running;
                8'h21: begin
                    if (!ext) begin
                        clear_next   = 1'b1;
                        running_next = 1'b0;
                    end
                end
                8'h55: begin
                    if (!ext && (speed != 3'd7)) speed_next = speed + 3'd1;
                end
                8'h4E: begin
                    if (!ext && (speed != 3'd0)) speed_next = speed - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x     <= '0;
            cursor_y     <= '0;
            running      <= 1'b0;
            speed        <= 3'(SPEED_INIT);
            toggle_pulse <= 1'b0;
            step_pulse   <= 1'b0;
            clear_pulse  <= 1'b0;
        end else begin
            cursor_x     <= cursor_x_next;
            cursor_y     <= cursor_y_next;
            running      <= running_next;
            speed        <= speed_next;
            toggle_pulse <= toggle_next;
            step_pulse   <= step_next;
            clear_pulse  <= clear_next;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder: cursor wrap, pulses,
// repeat suppression, run/step gating, clear, speed saturation and E0 handling.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_state = 1'b0;
    logic [4:0] cursor_x;
    logic [4:0] cursor_y;
    logic       running;
    logic [2:0] speed;
    logic       toggle_pulse, step_pulse, clear_pulse;

    int checks = 0;
    int failures = 0;
    int toggle_cnt = 0;
    int step_cnt = 0;
    int clear_cnt = 0;
    logic prev_toggle = 1'b0, prev_step = 1'b0, prev_clear = 1'b0;

    ps2_key_decoder #(
        .GRID_W(32), .GRID_H(32), .XW(5), .YW(5), .SPEED_INIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_byte(ps2_byte),
        .ps2_state(ps2_state),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .running(running),
        .speed(speed),
        .toggle_pulse(toggle_pulse),
        .step_pulse(step_pulse),
        .clear_pulse(clear_pulse)
    );

    always #5 clk = ~clk;

    // Pulses are tallied on the falling edge; a pulse seen high twice in a row is an error.
    always @(negedge clk) begin
        if (toggle_pulse) begin
            toggle_cnt++;
            checks++;
            if (prev_toggle) begin
                failures++;
                $display("[TB] FAIL toggle_single_cycle: high on consecutive cycles");
            end
        end
        if (step_pulse) begin
            step_cnt++;
            checks++;
            if (prev_step) begin
                failures++;
                $display("[TB] FAIL step_single_cycle: high on consecutive cycles");
            end
        end
        if (clear_pulse) begin
            clear_cnt++;
            checks++;
            if (prev_clear) begin
                failures++;
                $display("[TB] FAIL clear_single_cycle: high on consecutive cycles");
            end
        end
        prev_toggle = toggle_pulse;
        prev_step   = step_pulse;
        prev_clear  = clear_pulse;
    end

    task automatic release_key();
        @(negedge clk);
        ps2_state = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic make_key(input logic [7:0] b);
        @(negedge clk);
        ps2_byte  = b;
        ps2_state = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic tap(input logic [7:0] b);
        release_key();
        make_key(b);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks += 7;
        if (cursor_x !== 5'd0) begin failures++; $display("[TB] FAIL reset_cursor_x: got %0d want 0", cursor_x); end
        if (cursor_y !== 5'd0) begin failures++; $display("[TB] FAIL reset_cursor_y: got %0d want 0", cursor_y); end
        if (running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running: got %b want 0", running); end
        if (speed !== 3'd3) begin failures++; $display("[TB] FAIL reset_speed: got %0d want 3", speed); end
        if (toggle_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_toggle: got %b want 0", toggle_pulse); end
        if (step_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_step: got %b want 0", step_pulse); end
        if (clear_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_clear: got %b want 0", clear_pulse); end
    endtask

    task automatic test_cursor_wrap();
        @(negedge clk);
        ps2_byte  = 8'h6B;
        ps2_state = 1'b1;
        @(negedge clk);
        checks++;
        if (cursor_x !== 5'd0) begin failures++; $display("[TB] FAIL left_latency: got %0d want 0 after 1 clock", cursor_x); end
        @(negedge clk);
        checks++;
        if (cursor_x !== 5'd31) begin failures++; $display("[TB] FAIL left_wrap: got %0d want 31", cursor_x); end
        @(negedge clk);
        tap(8'h74);
        checks++;
        if (cursor_x !== 5'd0) begin failures++; $display("[TB] FAIL right_wrap: got %0d want 0", cursor_x); end
        tap(8'h75);
        checks++;
        if (cursor_y !== 5'd31) begin failures++; $display("[TB] FAIL up_wrap: got %0d want 31", cursor_y); end
        tap(8'h1B);
        checks++;
        if (cursor_y !== 5'd0) begin failures++; $display("[TB] FAIL s_down_wrap: got %0d want 0", cursor_y); end
        tap(8'h1C);
        tap(8'h1C);
        checks++;
        if (cursor_x !== 5'd30) begin failures++; $display("[TB] FAIL a_left: got %0d want 30", cursor_x); end
        tap(8'h23);
        checks++;
        if (cursor_x !== 5'd31) begin failures++; $display("[TB] FAIL d_right: got %0d want 31", cursor_x); end
        tap(8'h1D);
        tap(8'h72);
        tap(8'h72);
        checks++;
        if (cursor_y !== 5'd1) begin failures++; $display("[TB] FAIL w_down_mix: got %0d want 1", cursor_y); end
    endtask

    task automatic test_toggle_repeat();
        int base;
        base = toggle_cnt;
        release_key();
        @(negedge clk);
        ps2_byte  = 8'h29;
        ps2_state = 1'b1;
        @(negedge clk);
        checks++;
        if (toggle_pulse !== 1'b0) begin failures++; $display("[TB] FAIL toggle_early: got %b want 0", toggle_pulse); end
        @(negedge clk);
        checks++;
        if (toggle_pulse !== 1'b1) begin failures++; $display("[TB] FAIL toggle_pulse: got %b want 1", toggle_pulse); end
        @(negedge clk);
        checks++;
        if (toggle_pulse !== 1'b0) begin failures++; $display("[TB] FAIL toggle_width: got %b want 0", toggle_pulse); end
        repeat (1000) @(negedge clk);
        checks++;
        if (toggle_cnt !== base + 1) begin failures++; $display("[TB] FAIL toggle_hold: got %0d pulses want %0d", toggle_cnt - base, 1); end
        tap(8'h29);
        checks++;
        if (toggle_cnt !== base + 2) begin failures++; $display("[TB] FAIL toggle_repress: got %0d pulses want %0d", toggle_cnt - base, 2); end
    endtask

    task automatic test_run_step();
        int base;
        tap(8'h5A);
        checks++;
        if (running !== 1'b1) begin failures++; $display("[TB] FAIL enter_run: got %b want 1", running); end
        base = step_cnt;
        tap(8'h31);
        checks++;
        if (step_cnt !== base) begin failures++; $display("[TB] FAIL step_while_running: got %0d pulses want 0", step_cnt - base); end
        release_key();
        make_key(8'hE0);
        make_key(8'h5A);
        checks++;
        if (running !== 1'b0) begin failures++; $display("[TB] FAIL ext_enter_pause: got %b want 0", running); end
        tap(8'h31);
        checks++;
        if (step_cnt !== base + 1) begin failures++; $display("[TB] FAIL step_paused: got %0d pulses want 1", step_cnt - base); end
    endtask

    task automatic test_clear_speed();
        int base_clear, base_toggle, base_step;
        logic [2:0] exp_speed;
        tap(8'h5A);
        checks++;
        if (running !== 1'b1) begin failures++; $display("[TB] FAIL clear_setup_run: got %b want 1", running); end
        base_clear = clear_cnt;
        release_key();
        @(negedge clk);
        ps2_byte  = 8'h21;
        ps2_state = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if (clear_pulse !== 1'b1) begin failures++; $display("[TB] FAIL clear_pulse: got %b want 1", clear_pulse); end
        if (running !== 1'b0) begin failures++; $display("[TB] FAIL clear_stops_run: got %b want 0", running); end
        repeat (2) @(negedge clk);
        checks++;
        if (clear_cnt !== base_clear + 1) begin failures++; $display("[TB] FAIL clear_count: got %0d want 1", clear_cnt - base_clear); end
        exp_speed = 3'd3;
        for (int i = 0; i < 5; i++) begin
            tap(8'h55);
            if (exp_speed != 3'd7) exp_speed = exp_speed + 3'd1;
            checks++;
            if (speed !== exp_speed) begin failures++; $display("[TB] FAIL speed_up_%0d: got %0d want %0d", i, speed, exp_speed); end
        end
        for (int i = 0; i < 9; i++) begin
            tap(8'h4E);
            if (exp_speed != 3'd0) exp_speed = exp_speed - 3'd1;
            checks++;
            if (speed !== exp_speed) begin failures++; $display("[TB] FAIL speed_down_%0d: got %0d want %0d", i, speed, exp_speed); end
        end
        release_key();
        make_key(8'hE0);
        make_key(8'h55);
        checks++;
        if (speed !== 3'd0) begin failures++; $display("[TB] FAIL ext_plus_ignored: got %0d want 0", speed); end
        base_toggle = toggle_cnt;
        base_step   = step_cnt;
        release_key();
        make_key(8'h29);
        make_key(8'h31);
        checks += 2;
        if (toggle_cnt !== base_toggle + 1) begin failures++; $display("[TB] FAIL switch_toggle: got %0d want 1", toggle_cnt - base_toggle); end
        if (step_cnt !== base_step + 1) begin failures++; $display("[TB] FAIL switch_step: got %0d want 1", step_cnt - base_step); end
    endtask

    task automatic test_ext_reset();
        int base;
        base = toggle_cnt;
        release_key();
        make_key(8'hE0);
        make_key(8'h29);
        checks++;
        if (toggle_cnt !== base) begin failures++; $display("[TB] FAIL ext_space_ignored: got %0d want 0", toggle_cnt - base); end
        release_key();
        make_key(8'hE0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ps2_byte = 8'h29;
        repeat (3) @(negedge clk);
        checks += 2;
        if (toggle_cnt !== base + 1) begin failures++; $display("[TB] FAIL reset_clears_ext: got %0d want 1", toggle_cnt - base); end
        if (speed !== 3'd3) begin failures++; $display("[TB] FAIL midreset_speed: got %0d want 3", speed); end
    endtask

    initial begin
        test_reset();
        test_cursor_wrap();
        test_toggle_repeat();
        test_run_step();
        test_clear_speed();
        test_ext_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
